fetch_stage: RTL

- Instruction-fetch stage that feeds the IF/DC pipeline register of the pipelined CPU.
- Holds the PC and drives the instruction-memory address.
- Applies redirects resolved in decode (jump, branch, return) and owns the hardware return-address stack used by call/return push/pop.
- Outputs instruction, PC and valid to the decode stage every cycle.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/ras_stack.sv | 62 ++++++
 rtl/fetch_stage.sv | 99 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Next-PC select encoding, NOP word and default widths.
package fetch_pkg;

    localparam int PC_W_D      = 12;
    localparam int INSTR_W_D   = 19;
    localparam int RAS_DEPTH_D = 8;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_JMP = 2'b01,
        PC_BR  = 2'b10,
        PC_RET = 2'b11
    } pc_sel_e;

    localparam logic [INSTR_W_D-1:0] NOP = '0;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack; overflow overwrites the oldest entry.
// Sticky overflow/underflow flags clear only on reset.
module ras_stack #(
    parameter int RAS_DEPTH = 8,
    parameter int PC_W      = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] top,
    output logic            empty,
    output logic            full,
    output logic            ovf,
    output logic            unf
);

    localparam int SP_W = $clog2(RAS_DEPTH);
    localparam logic [SP_W-1:0] ONE = 1;
    localparam logic [SP_W:0] CNT_ONE = 1;
    localparam logic [SP_W:0] CNT_MAX = RAS_DEPTH[SP_W:0];

    logic [SP_W-1:0] sp;
    logic [SP_W-1:0] sp_m1;
    logic [SP_W:0]   count;
    logic [PC_W-1:0] mem [RAS_DEPTH];

    assign sp_m1 = sp - ONE;
    assign top   = mem[sp_m1];
    assign empty = (count == '0);
    assign full  = (count == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (push) begin
            sp <= sp + ONE;
            if (full)
                ovf <= 1'b1;
            else
                count <= count + CNT_ONE;
        end else if (pop) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                sp    <= sp_m1;
                count <= count - CNT_ONE;
            end
        end
    end

    // storage needs no reset; entries are only read while count > 0
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem[sp] <= din;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC mux, IF/DC register
// and the return-address stack used by call/return.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int PC_W      = PC_W_D,
    parameter int INSTR_W   = INSTR_W_D,
    parameter int RAS_DEPTH = RAS_DEPTH_D
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_i,
    input  logic               flush_i,
    input  logic [1:0]         pc_sel_i,
    input  logic [PC_W-1:0]    target_i,
    input  logic               push_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [INSTR_W-1:0] instr_dc_o,
    output logic [PC_W-1:0]    pc_dc_o,
    output logic               valid_dc_o,
    output logic               ras_ovf_o,
    output logic               ras_unf_o
);

    localparam logic [PC_W-1:0] PC_ONE = 1;

    pc_sel_e         sel;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full_unused;
    logic            ras_push;
    logic            ras_pop;
    logic            redirect;

    assign sel         = pc_sel_e'(pc_sel_i);
    assign redirect    = (sel != PC_SEQ);
    assign ras_push    = !stall_i && push_i && (sel == PC_JMP);
    assign ras_pop     = !stall_i && (sel == PC_RET);
    assign imem_addr_o = pc_q;

    always_comb begin
        pc_nxt = pc_q + PC_ONE;
        unique case (1'b1)
            (sel == PC_SEQ): pc_nxt = pc_q + PC_ONE;
            (sel == PC_JMP): pc_nxt = target_i;
            (sel == PC_BR):  pc_nxt = pc_dc_o + PC_ONE + target_i;
            (sel == PC_RET): pc_nxt = ras_empty ? '0 : ras_top;
            default:         pc_nxt = pc_q + PC_ONE;
        endcase
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .PC_W      (PC_W)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_dc_o + PC_ONE),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full_unused),
        .ovf   (ras_ovf_o),
        .unf   (ras_unf_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= '0;
            instr_dc_o <= INSTR_W'(NOP);
            pc_dc_o    <= '0;
            valid_dc_o <= 1'b0;
        end else begin
            if (!stall_i)
                pc_q <= pc_nxt;
            if (flush_i) begin
                instr_dc_o <= INSTR_W'(NOP);
                valid_dc_o <= 1'b0;
                if (!stall_i)
                    pc_dc_o <= pc_q;
            end else if (!stall_i) begin
                pc_dc_o <= pc_q;
                // a redirect means this cycle's fetch is wrong-path
                if (redirect) begin
                    instr_dc_o <= INSTR_W'(NOP);
                    valid_dc_o <= 1'b0;
                end else begin
                    instr_dc_o <= imem_data_i;
                    valid_dc_o <= 1'b1;
                end
            end
        end
    end

endmodule
